// File: rtl/oclib_uart_pkg.sv
// rtl/oclib_uart_pkg.sv - shared types and defaults for the UART byte-channel blocks
package oclib_uart_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam logic [7:0] DefaultTerminator  = 8'h0A;
   localparam int         DefaultIdleTimeout = 1024;

   // Index width that stays at least one bit wide when only a single requester exists.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/oclib_rr_pick.sv
// rtl/oclib_rr_pick.sv - rotating priority encoder: first set request at or after ptr, wrapping
module oclib_rr_pick
   import oclib_uart_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   logic [N-1:0] w_rot;
   int           w_sum;

   always_comb begin
      // Rotate so bit 0 is the requester at ptr; the lowest set bit is then the winner.
      w_rot = N'({req, req} >> ptr);
      any   = |req;
      w_sum = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_sum = int'(ptr) + i;
            if (w_sum >= N) w_sum = w_sum - N;
         end
      end
      idx = IW'(w_sum);
   end

endmodule

// File: rtl/oc_bc_tx_arbiter.sv
// rtl/oc_bc_tx_arbiter.sv - message-granular round-robin arbiter onto one shared byte channel
module oc_bc_tx_arbiter
   import oclib_uart_pkg::*;
#(
   parameter int         Ports       = 2,
   parameter logic [7:0] Terminator  = DefaultTerminator,
   parameter int         IdleTimeout = DefaultIdleTimeout
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [Ports-1:0]            inValid,
   input  logic [Ports*8-1:0]          inData,
   output logic [Ports-1:0]            inReady,
   output logic                        outValid,
   output logic [7:0]                  outData,
   input  logic                        outReady,
   output logic [idx_width(Ports)-1:0] grantId,
   output logic                        busy
);

   localparam int IW        = idx_width(Ports);
   localparam int IdleWidth = (IdleTimeout > 0) ? $clog2(IdleTimeout + 1) : 1;

   arb_state_e           r_state;
   arb_state_e           w_next_state;
   logic [IW-1:0]        r_rr_ptr;
   logic [IW-1:0]        r_grant_id;
   logic [IdleWidth-1:0] r_idle_count;
   logic [IdleWidth-1:0] w_idle_next;
   logic [IW-1:0]        w_pick;
   logic [IW-1:0]        w_next_ptr;
   logic                 w_any;
   logic                 w_release;
   logic                 w_gnt_valid;
   logic [7:0]           w_gnt_data;

   oclib_rr_pick #(
      .N  (Ports),
      .IW (IW)
   ) u_pick (
      .req (inValid),
      .ptr (r_rr_ptr),
      .any (w_any),
      .idx (w_pick)
   );

   assign grantId    = r_grant_id;
   assign w_next_ptr = (int'(r_grant_id) == Ports - 1) ? '0 : r_grant_id + IW'(1);

   always_comb begin
      w_next_state = r_state;
      w_idle_next  = r_idle_count;
      w_release    = 1'b0;
      w_gnt_valid  = inValid[r_grant_id];
      w_gnt_data   = inData[8*r_grant_id +: 8];
      inReady      = '0;
      outValid     = 1'b0;
      outData      = 8'h00;
      busy         = 1'b0;
      case (r_state)
         IDLE: begin
            w_idle_next = '0;
            if (w_any) w_next_state = GRANT;
         end
         GRANT: begin
            busy                = 1'b1;
            outValid            = w_gnt_valid;
            outData             = w_gnt_data;
            inReady[r_grant_id] = outReady;
            if (w_gnt_valid) begin
               // Stalled-but-valid counts as activity, so backpressure never forces a release.
               w_idle_next = '0;
               if (outReady && (w_gnt_data == Terminator)) w_release = 1'b1;
            end else begin
               if (int'(r_idle_count) < IdleTimeout) w_idle_next = r_idle_count + IdleWidth'(1);
               if ((IdleTimeout != 0) && (int'(r_idle_count) == IdleTimeout - 1)) w_release = 1'b1;
            end
            if (w_release) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rr_ptr     <= '0;
         r_grant_id   <= '0;
         r_idle_count <= '0;
      end else begin
         r_idle_count <= w_idle_next;
         if ((r_state == IDLE) && w_any) r_grant_id <= w_pick;
         if (w_release)                  r_rr_ptr   <= w_next_ptr;
      end
   end

endmodule

// File: tb/tb_oc_bc_tx_arbiter.sv
// tb/tb_oc_bc_tx_arbiter.sv - self-checking bench for oc_bc_tx_arbiter with a message-level model
module tb_oc_bc_tx_arbiter;

   localparam int P   = 4;
   localparam int TMO = 8;

   logic           clock = 1'b0;
   logic           reset;
   logic [P-1:0]   inValid;
   logic [P*8-1:0] inData;
   logic [P-1:0]   inReady;
   logic           outValid;
   logic [7:0]     outData;
   logic           outReady;
   logic [1:0]     grantId;
   logic           busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] mem [P][256];
   int         head [P];
   int         tail [P];
   logic [7:0] got_b [$];
   int         got_g [$];
   int         got_c [$];
   logic       s_busy, s_valid;
   logic [7:0] s_data;
   logic [1:0] s_gid;
   logic [P-1:0] s_ready;

   oc_bc_tx_arbiter #(.Ports(P), .Terminator(8'h0A), .IdleTimeout(TMO)) dut (
      .clock(clock), .reset(reset), .inValid(inValid), .inData(inData), .inReady(inReady),
      .outValid(outValid), .outData(outData), .outReady(outReady), .grantId(grantId), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic push(input int r, input logic [7:0] b);
      mem[r][tail[r]] = b;
      tail[r]++;
   endtask

   task automatic push_str(input int r, input string s);
      for (int k = 0; k < s.len(); k++) push(r, s[k]);
      push(r, 8'h0A);
   endtask

   task automatic clear_log();
      got_b.delete(); got_g.delete(); got_c.delete();
      cyc = 0;
   endtask

   task automatic clear_q();
      for (int i = 0; i < P; i++) begin head[i] = 0; tail[i] = 0; end
      clear_log();
   endtask

   // One clock: present each requester's head byte, sample at negedge, pop accepted bytes.
   task automatic step();
      logic [P-1:0] pop;
      for (int i = 0; i < P; i++) begin
         inValid[i]       = head[i] < tail[i];
         inData[8*i +: 8] = inValid[i] ? mem[i][head[i]] : 8'h00;
      end
      @(negedge clock);
      s_busy = busy; s_valid = outValid; s_data = outData; s_gid = grantId; s_ready = inReady;
      if (outValid === 1'b1 && outReady === 1'b1) begin
         got_b.push_back(outData); got_g.push_back(int'(grantId)); got_c.push_back(cyc);
      end
      pop = inValid & inReady;
      @(posedge clock);
      #1;
      for (int i = 0; i < P; i++) if (pop[i] === 1'b1) head[i]++;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b0; outReady = 1'b0;
      clear_q();
      step(); step();
      reset = 1'b1;
      clear_log();
   endtask

   task automatic test_reset();
      reset = 1'b0; outReady = 1'b1;
      clear_q();
      for (int i = 0; i < P; i++) push(i, 8'h41);
      step(); step();
      total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_outValid got %b want 0", s_valid); end
      total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", s_busy); end
      total++; if (s_ready !== 4'b0) begin bad++; $display("FAIL reset_inReady got %b want 0000", s_ready); end
      total++; if (s_gid !== 2'd0 || s_data !== 8'h00) begin bad++; $display("FAIL reset_gid_data got %0d/%h want 0/00", s_gid, s_data); end
   endtask

   task automatic test_single_message();
      logic [7:0] eb [3] = '{8'h41, 8'h42, 8'h0A};
      do_reset();
      outReady = 1'b1;
      push_str(0, "AB");
      step();
      total++; if (s_busy !== 1'b0 || s_valid !== 1'b0) begin bad++; $display("FAIL single_idle_gap got busy=%b valid=%b want 0/0", s_busy, s_valid); end
      repeat (4) step();
      total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL single_release got busy=%b want 0", s_busy); end
      total++;
      if (got_b.size() != 3) begin bad++; $display("FAIL single_count got %0d want 3", got_b.size()); end
      else for (int k = 0; k < 3; k++) begin
         if (got_b[k] !== eb[k] || got_g[k] != 0 || got_c[k] != k + 1) begin
            bad++; $display("FAIL single_byte%0d got %h/g%0d/c%0d want %h/g0/c%0d", k, got_b[k], got_g[k], got_c[k], eb[k], k + 1);
         end
      end
      push_str(0, "C"); push_str(1, "D");
      repeat (6) step();
      total++;
      if (got_b.size() != 7) begin bad++; $display("FAIL single_next_count got %0d want 7", got_b.size()); end
      else if (got_g[3] != 1 || got_b[3] !== 8'h44 || got_g[5] != 0 || got_b[5] !== 8'h43) begin
         bad++; $display("FAIL single_rrptr got g%0d %h then g%0d %h want g1 44 then g0 43", got_g[3], got_b[3], got_g[5], got_b[5]);
      end
   endtask

   task automatic test_two_requesters();
      int ec [6] = '{1, 2, 3, 5, 6, 7};
      int eg [6] = '{0, 0, 0, 1, 1, 1};
      logic [7:0] eb [6] = '{8'h41, 8'h42, 8'h0A, 8'h41, 8'h42, 8'h0A};
      do_reset();
      outReady = 1'b1;
      push_str(0, "AB"); push_str(1, "AB");
      repeat (10) step();
      total++;
      if (got_b.size() != 6) begin bad++; $display("FAIL two_count got %0d want 6", got_b.size()); end
      else for (int k = 0; k < 6; k++) begin
         if (got_b[k] !== eb[k] || got_g[k] != eg[k] || got_c[k] != ec[k]) begin
            bad++; $display("FAIL two_xfer%0d got %h/g%0d/c%0d want %h/g%0d/c%0d", k, got_b[k], got_g[k], got_c[k], eb[k], eg[k], ec[k]);
         end
      end
   endtask

   task automatic test_wrap();
      int eg [4] = '{0, 0, 2, 2};
      logic [7:0] eb [4] = '{8'h43, 8'h0A, 8'h44, 8'h0A};
      do_reset();
      outReady = 1'b1;
      push_str(2, "Z");
      repeat (4) step();
      clear_log();
      push_str(0, "C"); push_str(2, "D");
      repeat (8) step();
      total++;
      if (got_b.size() != 4) begin bad++; $display("FAIL wrap_count got %0d want 4", got_b.size()); end
      else for (int k = 0; k < 4; k++) begin
         if (got_b[k] !== eb[k] || got_g[k] != eg[k]) begin
            bad++; $display("FAIL wrap_xfer%0d got %h/g%0d want %h/g%0d", k, got_b[k], got_g[k], eb[k], eg[k]);
         end
      end
   endtask

   task automatic test_timeout();
      int n_busy;
      logic leak;
      do_reset();
      outReady = 1'b1;
      push(1, 8'h41);
      step(); step();
      push_str(0, "Q");
      n_busy = 0; leak = 1'b0;
      repeat (TMO) begin
         step();
         if (s_busy === 1'b1) n_busy++;
         if (s_ready[0] !== 1'b0 || s_valid !== 1'b0) leak = 1'b1;
      end
      total++; if (n_busy != TMO) begin bad++; $display("FAIL timeout_hold got %0d busy cycles want %0d", n_busy, TMO); end
      total++; if (leak !== 1'b0) begin bad++; $display("FAIL timeout_waiter got leak=%b want 0", leak); end
      step();
      total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL timeout_release got busy=%b want 0", s_busy); end
      step();
      total++;
      if (got_b.size() != 2 || got_g[1] != 0 || got_b[1] !== 8'h51 || got_c[1] != 11) begin
         bad++; $display("FAIL timeout_next got n=%0d want n=2 g0 byte 51 at cycle 11", got_b.size());
      end
   endtask

   task automatic test_backpressure();
      int n_stable;
      do_reset();
      outReady = 1'b0;
      push(3, 8'h55); push(3, 8'h0A);
      step();
      n_stable = 0;
      repeat (20) begin
         step();
         if (s_valid === 1'b1 && s_data === 8'h55 && s_busy === 1'b1 && s_gid === 2'd3) n_stable++;
      end
      total++; if (n_stable != 20 || got_b.size() != 0) begin bad++; $display("FAIL bp_hold got %0d stable, %0d xfers want 20, 0", n_stable, got_b.size()); end
      outReady = 1'b1;
      step(); step();
      total++;
      if (got_b.size() != 2 || got_b[0] !== 8'h55 || got_c[0] != 21 || got_b[1] !== 8'h0A) begin
         bad++; $display("FAIL bp_release got n=%0d want 55 at cycle 21 then 0a", got_b.size());
      end
   endtask

   task automatic test_reset_mid_message();
      do_reset();
      outReady = 1'b1;
      push_str(0, "X"); push_str(1, "abcd");
      repeat (6) step();
      total++; if (got_b.size() != 4 || got_g[3] != 1) begin bad++; $display("FAIL mid_setup got n=%0d want 4 with last grant 1", got_b.size()); end
      reset = 1'b0; outReady = 1'b0;
      step(); step();
      total++;
      if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_gid !== 2'd0) begin
         bad++; $display("FAIL mid_reset got valid=%b busy=%b gid=%0d want 0/0/0", s_valid, s_busy, s_gid);
      end
      reset = 1'b1; outReady = 1'b1;
      push_str(0, "Y");
      step(); step();
      total++; if (got_b.size() != 5 || got_g[4] != 0 || got_b[4] !== 8'h59) begin bad++; $display("FAIL mid_restart got n=%0d want 5 with g0 byte 59", got_b.size()); end
   endtask

   // Model: every queued message waits; each handoff takes the next non-empty requester after the last one served.
   task automatic test_random();
      logic [7:0] exp_b [$];
      int         exp_g [$];
      int         pos [P];
      int         ptr, found, c, budget;
      logic       ready_bad;
      for (int round = 0; round < 20; round++) begin
         do_reset();
         for (int r = 0; r < P; r++) begin
            int nmsg = $urandom_range(0, 3);
            for (int m = 0; m < nmsg; m++) begin
               int len = $urandom_range(0, 4);
               for (int k = 0; k < len; k++) push(r, 8'($urandom_range(8'h0B, 8'hFF)));
               push(r, 8'h0A);
            end
         end
         exp_b.delete(); exp_g.delete();
         for (int r = 0; r < P; r++) pos[r] = 0;
         ptr = 0; found = 0;
         while (found >= 0) begin
            found = -1;
            for (int k = 0; k < P; k++) begin
               c = (ptr + k) % P;
               if (found < 0 && pos[c] < tail[c]) found = c;
            end
            if (found >= 0) begin
               do begin
                  exp_b.push_back(mem[found][pos[found]]); exp_g.push_back(found); pos[found]++;
               end while (mem[found][pos[found]-1] != 8'h0A);
               ptr = (found + 1) % P;
            end
         end
         budget = 0; ready_bad = 1'b0;
         while (got_b.size() < exp_b.size() && budget < 2000) begin
            outReady = ($urandom_range(0, 9) < 7);
            step();
            if (s_ready !== (s_busy ? (4'(outReady) << s_gid) : 4'b0)) ready_bad = 1'b1;
            budget++;
         end
         total++; if (ready_bad !== 1'b0) begin bad++; $display("FAIL rand%0d_inReady got stray ready want one-hot on grant", round); end
         total++;
         if (got_b.size() != exp_b.size()) begin bad++; $display("FAIL rand%0d_count got %0d want %0d", round, got_b.size(), exp_b.size()); end
         else for (int k = 0; k < exp_b.size(); k++) begin
            if (got_b[k] !== exp_b[k] || got_g[k] != exp_g[k]) begin
               bad++; $display("FAIL rand%0d_xfer%0d got %h/g%0d want %h/g%0d", round, k, got_b[k], got_g[k], exp_b[k], exp_g[k]);
            end
         end
      end
   endtask

   initial begin
      inValid = '0; inData = '0; outReady = 1'b0; reset = 1'b0;
      test_reset();
      test_single_message();
      test_two_requesters();
      test_wrap();
      test_timeout();
      test_backpressure();
      test_reset_mid_message();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/oc_bc_tx_arbiter.md
Name: oc_bc_tx_arbiter

Overview:
- Shares one 8-bit byte channel (the UART TX side feeding oclib_uart) between Ports independent byte-stream requesters.
- Grants are message-granular: a grant is held until the requester sends a terminator byte or goes idle for IdleTimeout cycles. Bytes from different requesters never interleave within a message.
- Sits between debug/status producers and the uart/control byte channel at top level.

Parameters:
- Ports, 2, number of requesters (2..16).
- Terminator, 8'h0A, byte value that ends a message and releases the grant.
- IdleTimeout, 1024, cycles of no valid from the granted requester before forced release; 0 disables timeout.
- IdleWidth, $clog2(IdleTimeout+1) (minimum 1), idle counter width (derived, not overridden).

Ports:
- clock  input  1  block clock.
- reset  input  1  synchronous, active-low reset.
- inValid  input  Ports  per-requester byte valid.
- inData  input  Ports*8  per-requester byte; requester i occupies bits [8i+7:8i].
- inReady  output  Ports  per-requester ready.
- outValid  output  1  shared channel valid.
- outData  output  8  shared channel byte.
- outReady  input  1  shared channel ready.
- grantId  output  $clog2(Ports)  index of the current or most recent grant.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (reset==0 at a clock edge) sets:
  - state=IDLE, rrPtr=0, grantId=0, idleCount=0.
  - While in IDLE: outValid=0, outData=0, inReady all 0, busy=0.
- A transfer on any channel occurs when valid and ready are both high on the same edge. Valid/ready follow the codebase byte-channel rules: once asserted, valid holds until the transfer.
- State IDLE:
  - No data passes.
  - If any inValid is high, pick the first requester at or after rrPtr, scanning upward and wrapping modulo Ports.
  - Next cycle: grantId=pick, state=GRANT. Arbitration latency is exactly 1 cycle.
- State GRANT (g = grantId):
  - Combinational pass-through with zero latency: outValid=inValid[g], outData=inData[g], inReady[g]=outReady. All other inReady bits are 0. busy=1.
  - Release on terminator: a transfer with outData==Terminator moves state to IDLE and sets rrPtr=(g+1) mod Ports on the following edge.
  - Idle counter: if inValid[g]==0, idleCount increments, saturating at IdleTimeout. If inValid[g]==1, idleCount clears. Backpressure (valid high, outReady low) is not idle.
  - Release on timeout: when IdleTimeout!=0 and idleCount reaches IdleTimeout-1 while inValid[g]==0, go to IDLE with the same rrPtr update.
  - Timeout release requires inValid[g]==0, so a valid byte is never retracted.
  - idleCount clears on every entry to GRANT.
- Boundary conditions:
  - Terminator and timeout cannot coincide, because terminator release requires valid and timeout requires no valid.
  - A requester raising valid during another's grant waits. Worst-case wait is (Ports-1) messages plus one IDLE cycle per handoff.
  - Single active requester: it is re-granted after one IDLE cycle per message, and its traffic is otherwise uninterrupted.
  - rrPtr wraps from Ports-1 to 0.
  - rrPtr changes only on release, never in IDLE.
  - Reset mid-message drops the grant immediately. Downstream sees outValid=0 in the cycle after the reset edge, and a partial message may be truncated (accepted).
  - Ports==1: always picks 0; the IDLE gap between messages still applies.
  - grantId holds its last value while in IDLE.

Decomposition:
- oclib_uart_pkg gains:
  - the state enum (IDLE, GRANT);
  - localparam DefaultTerminator=8'h0A;
  - localparam DefaultIdleTimeout=1024.
- Sub-module oclib_rr_pick: combinational rotating priority encoder.
  - Inputs: req[N], ptr.
  - Outputs: any, idx.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Requester 0 sends 0x41,0x42,0x0A with outReady=1 → one IDLE cycle, then 3 consecutive out transfers. grantId=0. Return to IDLE, rrPtr=1.
- Requesters 0 and 1 both valid from reset, each sending "AB\n" → output is A,B,0x0A from 0, then A,B,0x0A from 1. No interleaving; exactly one IDLE cycle between messages.
- Ports=4, rrPtr=3, requesters 0 and 2 valid → grant 0 (wrap). After release rrPtr=1, so the next grant is 2.
- IdleTimeout=8: requester 1 sends 0x41 then drops valid → release after exactly 8 idle cycles. busy=0 and requester 0 is granted next.
- Granted requester valid with outReady=0 for 20 cycles, IdleTimeout=8 → no release, byte held stable, transfers when outReady rises.
- reset low mid-message (after 2 of 5 bytes) → next cycle outValid=0, busy=0, rrPtr=0, grantId=0. After reset is released, arbitration restarts from requester 0.
